acc_sequencer: RTL and testbench
================================

Name: acc_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit accumulator machine.
- Sequences fetch, decode and execute by driving write enables and mux selects for the ACC, MAR, MBR, IR and PC registers, plus the ALU opcode and the main-memory write enable.
- Memory read data is registered, so a read returns data one clock after MAR is valid.
- Instruction format: opcode = instruction[15:12], operand/address = instruction[11:0], zero-extended to 16 bits by the datapath.

Parameters:
- HALT_ON_ILLEGAL, 0, 1 = an illegal opcode enters HALT; 0 = it is skipped as a NOP.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  16  current IR contents.
- acc_zero  in  1  high when ACC == 16'h0000.
- resume  in  1  leaves HALT; sampled only in HALT.
- mar_we / mbr_we / ir_we / pc_we / acc_we  out  1 each  register write enables.
- mar_sel  out  1  0 = PC, 1 = IR[11:0].
- mbr_sel  out  1  0 = memory data_out, 1 = ACC.
- pc_sel  out  1  0 = PC+1, 1 = IR[11:0].
- acc_sel  out  2  0 = ALU result, 1 = MBR, 2 = immediate IR[11:0], 3 = reserved (never driven).
- alu_op  out  4  ALU opcode; operand1 = ACC, operand2 = MBR.
- mem_we  out  1  main-memory write enable.
- halted  out  1  high in HALT.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is illegal.
- instr_count  out  CNT_W  retired-instruction counter.
- state  out  4  debug encoding of the current state.

Behaviour:
- ISA:
  - 0 HALT, 1 LOAD a, 2 STORE a, 3 ADD a, 4 SUB a, 5 AND a, 6 OR a, 7 XOR a.
  - 8 JMP a, 9 JZ a, A SHL, B SHR, C LOADI imm.
  - D–F are illegal.
- States and encodings: FETCH_MAR 0, FETCH_WAIT 1, FETCH_MBR 2, FETCH_IR 3, DECODE 4, OP_MAR 5, OP_WAIT 6, OP_MBR 7, EXEC_ACC 8, ST_MBR 9, ST_WRITE 10, JUMP 11, HALT 12.
- Outputs are decoded combinationally from the state and the IR opcode. Every output not listed as asserted for a state is 0.
- Fetch sequence:
  - FETCH_MAR: mar_we=1, mar_sel=0.
  - FETCH_WAIT: nothing asserted.
  - FETCH_MBR: mbr_we=1, mbr_sel=0.
  - FETCH_IR: ir_we=1, pc_we=1, pc_sel=0; instr_count increments.
  - Then DECODE.
- DECODE routing:
  - LOAD/ADD/SUB/AND/OR/XOR/STORE → OP_MAR.
  - SHL/SHR/LOADI → EXEC_ACC.
  - JMP/JZ → JUMP.
  - HALT → HALT.
  - Illegal → illegal_op=1, then FETCH_MAR (or HALT if HALT_ON_ILLEGAL=1).
- OP_MAR: mar_we=1, mar_sel=1. Next state is ST_MBR for STORE, otherwise OP_WAIT.
- OP_WAIT → OP_MBR (mbr_we=1, mbr_sel=0) → EXEC_ACC.
- EXEC_ACC: acc_we=1, then FETCH_MAR.
  - LOAD: acc_sel=1.
  - LOADI: acc_sel=2.
  - Otherwise acc_sel=0 with alu_op: ADD 0000, SUB 0001, SHL 0100, SHR 0101, AND 1000, OR 1001, XOR 1010.
  - alu_op is 0000 in all other states.
- ST_MBR: mbr_we=1, mbr_sel=1.
- ST_WRITE: mem_we=1, then FETCH_MAR.
- JUMP:
  - pc_sel=1.
  - pc_we=1 for JMP; pc_we=acc_zero for JZ.
  - Then FETCH_MAR.
- HALT: halted=1. Stay in HALT while resume=0; resume=1 → FETCH_MAR on the next edge.
- Cycle counts including fetch and decode: LOAD/ALU-memory ops 9, STORE 8, SHL/SHR/LOADI/JMP/JZ 6, illegal 5.
- Counter: instr_count counts fetches, including HALT and illegal opcodes. It wraps from all-ones to 0 with no flag.
- Reset:
  - Asynchronous: state → FETCH_MAR, instr_count → 0.
  - While reset=1, all write enables and mem_we are forced 0, halted=0, illegal_op=0.
  - Reset mid-instruction abandons it. No partial memory write occurs after reset asserts.
  - The first fetch begins on the first rising edge after reset deasserts.
- resume is ignored outside HALT.
- acc_zero is sampled only in JUMP.

Test Plan:
- Reset, release; IR=16'h1005 (LOAD 5) → states 0,1,2,3,4,5,6,7,8; acc_we=1 with acc_sel=1 in cycle 9; instr_count=1.
- IR=16'h2010 (STORE 0x10) → mar_sel=1 in OP_MAR, mbr_sel=1 in ST_MBR, mem_we=1 only in cycle 8, back to FETCH_MAR.
- IR=16'h9020 (JZ) with acc_zero=0 → pc_we=0 in JUMP. Repeat with acc_zero=1 → pc_we=1, pc_sel=1. Both take 6 cycles.
- IR=16'h0000 → halted=1, held 20 cycles with resume=0; resume pulse → FETCH_MAR next edge, halted=0.
- IR=16'hE000 with HALT_ON_ILLEGAL=0 → illegal_op one-cycle pulse in DECODE, 5-cycle instruction. With HALT_ON_ILLEGAL=1 → HALT.
- Assert reset during ST_MBR → mem_we never asserts, state=0 immediately without a clock edge; preload instr_count=16'hFFFF and fetch → 16'h0000.

Source files
------------

// File: rtl/acc_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit accumulator machine.
// Drives register write enables, mux selects, ALU opcode and memory write from state + IR opcode.
module acc_sequencer #(
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instruction,
  input  logic             acc_zero,
  input  logic             resume,
  output logic             mar_we,
  output logic             mbr_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             acc_we,
  output logic             mar_sel,
  output logic             mbr_sel,
  output logic             pc_sel,
  output logic [1:0]       acc_sel,
  output logic [3:0]       alu_op,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH_MAR  = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_FETCH_MBR  = 4'd2,
    S_FETCH_IR   = 4'd3,
    S_DECODE     = 4'd4,
    S_OP_MAR     = 4'd5,
    S_OP_WAIT    = 4'd6,
    S_OP_MBR     = 4'd7,
    S_EXEC_ACC   = 4'd8,
    S_ST_MBR     = 4'd9,
    S_ST_WRITE   = 4'd10,
    S_JUMP       = 4'd11,
    S_HALT       = 4'd12
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_LOADI = 4'hC;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       opcode;
  logic             is_illegal;
  logic             unused_operand;

  assign opcode         = instruction[15:12];
  assign is_illegal     = (opcode >= 4'hD);
  // The operand field is consumed by the datapath muxes, not by the sequencer.
  assign unused_operand = ^instruction[11:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH_MAR:  state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_FETCH_MBR;
      S_FETCH_MBR:  state_d = S_FETCH_IR;
      S_FETCH_IR:   state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR:           state_d = S_OP_MAR;
          OP_SHL, OP_SHR, OP_LOADI:        state_d = S_EXEC_ACC;
          OP_JMP, OP_JZ:                   state_d = S_JUMP;
          OP_HALT:                         state_d = S_HALT;
          default: state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH_MAR;
        endcase
      end
      S_OP_MAR:     state_d = (opcode == OP_STORE) ? S_ST_MBR : S_OP_WAIT;
      S_OP_WAIT:    state_d = S_OP_MBR;
      S_OP_MBR:     state_d = S_EXEC_ACC;
      S_EXEC_ACC:   state_d = S_FETCH_MAR;
      S_ST_MBR:     state_d = S_ST_WRITE;
      S_ST_WRITE:   state_d = S_FETCH_MAR;
      S_JUMP:       state_d = S_FETCH_MAR;
      S_HALT:       state_d = resume ? S_FETCH_MAR : S_HALT;
      default:      state_d = S_FETCH_MAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH_MAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH_IR) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Everything is gated by reset so an interrupted store can never write memory.
  always_comb begin
    mar_we     = 1'b0;
    mbr_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    acc_we     = 1'b0;
    mar_sel    = 1'b0;
    mbr_sel    = 1'b0;
    pc_sel     = 1'b0;
    acc_sel    = 2'd0;
    alu_op     = 4'b0000;
    mem_we     = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH_MAR: mar_we = 1'b1;
        S_FETCH_MBR: mbr_we = 1'b1;
        S_FETCH_IR: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        S_DECODE:    illegal_op = is_illegal;
        S_OP_MAR: begin
          mar_we  = 1'b1;
          mar_sel = 1'b1;
        end
        S_OP_MBR:    mbr_we = 1'b1;
        S_EXEC_ACC: begin
          acc_we = 1'b1;
          case (opcode)
            OP_LOAD:  acc_sel = 2'd1;
            OP_LOADI: acc_sel = 2'd2;
            OP_ADD:   alu_op  = 4'b0000;
            OP_SUB:   alu_op  = 4'b0001;
            OP_SHL:   alu_op  = 4'b0100;
            OP_SHR:   alu_op  = 4'b0101;
            OP_AND:   alu_op  = 4'b1000;
            OP_OR:    alu_op  = 4'b1001;
            OP_XOR:   alu_op  = 4'b1010;
            default:  alu_op  = 4'b0000;
          endcase
        end
        S_ST_MBR: begin
          mbr_we  = 1'b1;
          mbr_sel = 1'b1;
        end
        S_ST_WRITE:  mem_we = 1'b1;
        S_JUMP: begin
          pc_sel = 1'b1;
          pc_we  = (opcode == OP_JMP) || ((opcode == OP_JZ) && acc_zero);
        end
        S_HALT:      halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: the driver queues the hand-derived per-cycle output word,
// a negedge monitor pops and compares it against the observed outputs.
module tb_acc_sequencer;

  localparam int W = 37;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_b = 1'b1;
  logic [15:0] instruction = 16'h0000;
  logic        acc_zero = 1'b0;
  logic        resume = 1'b0;

  logic        mar_we, mbr_we, ir_we, pc_we, acc_we, mar_sel, mbr_sel, pc_sel;
  logic [1:0]  acc_sel;
  logic [3:0]  alu_op;
  logic        mem_we, halted, illegal_op;
  logic [15:0] instr_count;
  logic [3:0]  state;

  logic        mar_we_b, mbr_we_b, ir_we_b, pc_we_b, acc_we_b, mar_sel_b, mbr_sel_b, pc_sel_b;
  logic [1:0]  acc_sel_b;
  logic [3:0]  alu_op_b;
  logic        mem_we_b, halted_b, illegal_op_b;
  logic [2:0]  instr_count_b;
  logic [3:0]  state_b;

  // clock / reset
  always #5 clk = ~clk;

  acc_sequencer #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .instruction(instruction), .acc_zero(acc_zero), .resume(resume),
    .mar_we(mar_we), .mbr_we(mbr_we), .ir_we(ir_we), .pc_we(pc_we), .acc_we(acc_we),
    .mar_sel(mar_sel), .mbr_sel(mbr_sel), .pc_sel(pc_sel), .acc_sel(acc_sel), .alu_op(alu_op),
    .mem_we(mem_we), .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count),
    .state(state)
  );

  acc_sequencer #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset_b), .instruction(instruction), .acc_zero(acc_zero), .resume(resume),
    .mar_we(mar_we_b), .mbr_we(mbr_we_b), .ir_we(ir_we_b), .pc_we(pc_we_b), .acc_we(acc_we_b),
    .mar_sel(mar_sel_b), .mbr_sel(mbr_sel_b), .pc_sel(pc_sel_b), .acc_sel(acc_sel_b),
    .alu_op(alu_op_b), .mem_we(mem_we_b), .halted(halted_b), .illegal_op(illegal_op_b),
    .instr_count(instr_count_b), .state(state_b)
  );

  // Observed word: {state, mar_we, mar_sel, mbr_we, mbr_sel, ir_we, pc_we, pc_sel, acc_we,
  //                 acc_sel, alu_op, mem_we, halted, illegal_op, instr_count}
  wire [W-1:0] act_a = {state, mar_we, mar_sel, mbr_we, mbr_sel, ir_we, pc_we, pc_sel, acc_we,
                        acc_sel, alu_op, mem_we, halted, illegal_op, instr_count};
  wire [W-1:0] act_b = {state_b, mar_we_b, mar_sel_b, mbr_we_b, mbr_sel_b, ir_we_b, pc_we_b,
                        pc_sel_b, acc_we_b, acc_sel_b, alu_op_b, mem_we_b, halted_b,
                        illegal_op_b, 13'd0, instr_count_b};

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic         sel_b = 1'b0;
  string        tag = "idle";

  // ctl = {mar_we, mar_sel, mbr_we, mbr_sel, ir_we, pc_we, pc_sel, acc_we}
  // flg = {mem_we, halted, illegal_op}
  function automatic logic [W-1:0] ov(input logic [3:0] st, input logic [7:0] ctl,
                                      input logic [1:0] asel, input logic [3:0] aop,
                                      input logic [2:0] flg, input logic [15:0] cnt);
    return {st, ctl, asel, aop, flg, cnt};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check(tag, sel_b ? act_b : act_a, e);
    end
  end

  // driver tasks: queue the expectation for the current cycle, then advance one clock
  task automatic cyc(input logic [W-1:0] v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] c);
    cyc(ov(4'd0, 8'b1000_0000, 2'd0, 4'd0, 3'b000, c));
    cyc(ov(4'd1, 8'b0000_0000, 2'd0, 4'd0, 3'b000, c));
    cyc(ov(4'd2, 8'b0010_0000, 2'd0, 4'd0, 3'b000, c));
    cyc(ov(4'd3, 8'b0000_1100, 2'd0, 4'd0, 3'b000, c));
  endtask

  task automatic mem_alu(input logic [15:0] c, input logic [15:0] cn,
                         input logic [1:0] asel, input logic [3:0] aop);
    fetch(c);
    cyc(ov(4'd4, 8'b0000_0000, 2'd0, 4'd0, 3'b000, cn));
    cyc(ov(4'd5, 8'b1100_0000, 2'd0, 4'd0, 3'b000, cn));
    cyc(ov(4'd6, 8'b0000_0000, 2'd0, 4'd0, 3'b000, cn));
    cyc(ov(4'd7, 8'b0010_0000, 2'd0, 4'd0, 3'b000, cn));
    cyc(ov(4'd8, 8'b0000_0001, asel, aop, 3'b000, cn));
  endtask

  task automatic reg_op(input logic [15:0] c, input logic [15:0] cn,
                        input logic [1:0] asel, input logic [3:0] aop);
    fetch(c);
    cyc(ov(4'd4, 8'b0000_0000, 2'd0, 4'd0, 3'b000, cn));
    cyc(ov(4'd8, 8'b0000_0001, asel, aop, 3'b000, cn));
  endtask

  task automatic jump_op(input logic [15:0] c, input logic [7:0] jctl);
    fetch(c);
    cyc(ov(4'd4, 8'b0000_0000, 2'd0, 4'd0, 3'b000, c + 16'd1));
    cyc(ov(4'd11, jctl, 2'd0, 4'd0, 3'b000, c + 16'd1));
  endtask

  initial begin
    @(posedge clk);
    #1;
    tag = "reset";
    instruction = 16'h1005;
    repeat (3) cyc(ov(4'd0, 8'h00, 2'd0, 4'd0, 3'b000, 16'd0));
    reset = 1'b0;

    tag = "load";   mem_alu(16'd0, 16'd1, 2'd1, 4'b0000);

    tag = "store";  instruction = 16'h2010;
    fetch(16'd1);
    cyc(ov(4'd4,  8'b0000_0000, 2'd0, 4'd0, 3'b000, 16'd2));
    cyc(ov(4'd5,  8'b1100_0000, 2'd0, 4'd0, 3'b000, 16'd2));
    cyc(ov(4'd9,  8'b0011_0000, 2'd0, 4'd0, 3'b000, 16'd2));
    cyc(ov(4'd10, 8'b0000_0000, 2'd0, 4'd0, 3'b100, 16'd2));

    tag = "sub";    instruction = 16'h4005; mem_alu(16'd2, 16'd3, 2'd0, 4'b0001);
    tag = "xor";    instruction = 16'h7005; mem_alu(16'd3, 16'd4, 2'd0, 4'b1010);
    tag = "shl";    instruction = 16'hA000; resume = 1'b1; reg_op(16'd4, 16'd5, 2'd0, 4'b0100);
    resume = 1'b0;
    tag = "loadi";  instruction = 16'hC0FF; reg_op(16'd5, 16'd6, 2'd2, 4'b0000);
    tag = "jz_nz";  instruction = 16'h9020; acc_zero = 1'b0; jump_op(16'd6, 8'b0000_0010);
    tag = "jz_z";   acc_zero = 1'b1; jump_op(16'd7, 8'b0000_0110);
    tag = "jmp";    instruction = 16'h8030; acc_zero = 1'b0; jump_op(16'd8, 8'b0000_0110);

    tag = "halt";   instruction = 16'h0000;
    fetch(16'd9);
    cyc(ov(4'd4, 8'h00, 2'd0, 4'd0, 3'b000, 16'd10));
    repeat (20) cyc(ov(4'd12, 8'h00, 2'd0, 4'd0, 3'b010, 16'd10));
    resume = 1'b1;
    cyc(ov(4'd12, 8'h00, 2'd0, 4'd0, 3'b010, 16'd10));
    resume = 1'b0;

    tag = "illegal"; instruction = 16'hE000;
    fetch(16'd10);
    cyc(ov(4'd4, 8'h00, 2'd0, 4'd0, 3'b001, 16'd11));

    tag = "store_reset"; instruction = 16'h2010;
    fetch(16'd11);
    cyc(ov(4'd4, 8'h00,        2'd0, 4'd0, 3'b000, 16'd12));
    cyc(ov(4'd5, 8'b1100_0000, 2'd0, 4'd0, 3'b000, 16'd12));
    reset = 1'b1;
    #1;
    check("async_reset", act_a, ov(4'd0, 8'h00, 2'd0, 4'd0, 3'b000, 16'd0));
    cyc(ov(4'd0, 8'h00, 2'd0, 4'd0, 3'b000, 16'd0));
    cyc(ov(4'd0, 8'h00, 2'd0, 4'd0, 3'b000, 16'd0));
    reset = 1'b0;
    tag = "after_reset";
    fetch(16'd0);
    cyc(ov(4'd4, 8'h00, 2'd0, 4'd0, 3'b000, 16'd1));
    reset = 1'b1;

    sel_b = 1'b1;
    tag = "b_illegal_halt"; instruction = 16'hF123; reset_b = 1'b0;
    fetch(16'd0);
    cyc(ov(4'd4,  8'h00, 2'd0, 4'd0, 3'b001, 16'd1));
    cyc(ov(4'd12, 8'h00, 2'd0, 4'd0, 3'b010, 16'd1));
    resume = 1'b1;
    cyc(ov(4'd12, 8'h00, 2'd0, 4'd0, 3'b010, 16'd1));
    resume = 1'b0;

    tag = "b_wrap"; instruction = 16'hB000;
    for (int i = 1; i < 8; i++) reg_op(16'(i), 16'((i + 1) % 8), 2'd0, 4'b0101);
    fetch(16'd0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
